io_loader_router: RTL and testbench
===================================

Name: io_loader_router

Overview:
- Byte-level I/O front end between the UART transceiver and the core. Replaces the fixed boot loader.
- After reset it assembles received bytes into words and loads, in order:
  - a length-prefixed instruction image into instruction memory;
  - a length-prefixed data image into data memory (cache write port, with back-pressure).
- It then switches to run mode: received words fill an input FIFO for the core, and core output bytes drain through an output FIFO to the transmitter.
- Generalised over word width, load base addresses, FIFO depths and byte order. Adds overrun detection and zero-length image skipping.

Parameters:
- WORD_BYTES, 4, bytes per assembled word (word width W = 8*WORD_BYTES).
- INSTR_BASE, 32'h0, first instruction write address.
- DATA_BASE, 32'h40000, first data write address.
- ADDR_STEP, WORD_BYTES, address increment per written word.
- IN_DEPTH, 8, input FIFO depth in words (power of 2, >=2).
- OUT_DEPTH, 16, output FIFO depth in bytes (power of 2, >=2).
- BIG_ENDIAN, 0, 0: first byte received is LSB of the word; 1: first byte received is MSB.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- rx_data  in  8  received byte from UART receiver
- rx_valid  in  1  one-cycle strobe; no back-pressure possible
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte when tx_valid&tx_ready
- instr_we  out  1  one-cycle instruction-memory write strobe
- instr_addr  out  32  instruction write address
- instr_wdata  out  W  instruction word
- data_wvalid  out  1  data write request, held until accepted
- data_wready  in  1  cache accepts write when data_wvalid&data_wready
- data_addr  out  32  data write address
- data_wdata  out  W  data word
- io_stall  out  1  core held while 1
- in_valid  out  1  input FIFO non-empty
- in_data  out  W  head of input FIFO
- in_ready  in  1  core pops on in_valid&in_ready
- out_valid  in  1  core pushes out_data when out_valid&!out_busy
- out_data  in  8  output byte
- out_busy  out  1  output FIFO full
- err_overrun  out  1  sticky: a completed word was dropped
- load_state  out  3  current FSM state (debug)

Behaviour:
- Clock and reset: one clock, clk. rstn is synchronous and active-low; all state is updated on the posedge of clk only.
- Reset values:
  - FSM=S_ILEN; io_stall=1.
  - instr_we=0, data_wvalid=0, tx_valid=0, in_valid=0, out_busy=0, err_overrun=0.
  - Byte counter=0; instr_addr=INSTR_BASE; data_addr=DATA_BASE.
  - Both FIFOs empty.
- Reset mid-load discards any partial word and all FIFO contents.
- Word assembly:
  - A byte counter counts rx_valid strobes modulo WORD_BYTES.
  - Bytes are shifted in per BIG_ENDIAN.
  - A "word done" event fires in the cycle after the last byte is sampled.
- FSM states: S_ILEN, S_INSTR, S_DLEN, S_DATA, S_DRAIN, S_RUN.
- S_ILEN: the word done event loads the instruction count N (lower 32 bits). N=0 -> S_DLEN; otherwise -> S_INSTR.
- S_INSTR:
  - Each word done produces a one-cycle instr_we pulse with instr_wdata = word and instr_addr = current address.
  - instr_addr increments by ADDR_STEP the cycle after each pulse.
  - After the Nth word -> S_DLEN.
- S_DLEN: the word done event loads the data count M. M=0 -> S_RUN; otherwise -> S_DATA.
- S_DATA:
  - Each word done loads a single pending register and raises data_wvalid.
  - data_wvalid, data_addr and data_wdata stay stable until data_wready. On acceptance, data_wvalid drops next cycle and data_addr += ADDR_STEP.
  - If a word completes while the pending register is still occupied and not being accepted that cycle, the word is dropped and err_overrun is set. The word count still advances.
  - After the Mth word completes -> S_DRAIN.
- S_DRAIN: wait until the final pending write is accepted, then -> S_RUN.
- S_RUN:
  - io_stall=0, registered: it falls in the first cycle the FSM is in S_RUN.
  - Each word done pushes into the input FIFO. If the FIFO is full, the word is dropped and err_overrun is set.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full; in that case no overrun occurs.
  - in_data shows the head word combinationally from the FIFO storage. The FIFO is first-word-fall-through, so an empty-to-non-empty push raises in_valid on the next cycle.
- Output path (active in all states):
  - The output FIFO is written when out_valid&!out_busy; out_busy = full.
  - tx_valid = non-empty; tx_data = head byte; pop on tx_valid&tx_ready.
  - Simultaneous push and pop is allowed.
  - FIFO pointers wrap modulo the depth; an extra pointer bit distinguishes full from empty.
- rx bytes arriving in S_DRAIN start assembly of the first run-mode word and are not lost.
- err_overrun clears only on reset.

Test Plan:
- Load N=2 (bytes 02 00 00 00), words 0x11223344, 0xAABBCCDD, then M=0, BIG_ENDIAN=0 -> two instr_we pulses with (0x0, 0x11223344) and (0x4, 0xAABBCCDD); io_stall falls after the DLEN word; no data_wvalid.
- N=0, M=3, data_wready tied 1 -> data writes to 0x40000, 0x40004, 0x40008; S_DRAIN then S_RUN; err_overrun=0.
- M=2, data_wready held 0 for 10 cycles, bytes sent back-to-back -> first write held stable, second word dropped, err_overrun=1, only one write to 0x40000 completes.
- RUN mode, IN_DEPTH=8, send 9 words with in_ready=0 -> in_valid=1, err_overrun=1 on the 9th; popping returns the first 8 in order.
- Core pushes 20 bytes, tx_ready=0, OUT_DEPTH=16 -> out_busy=1 after the 16th push; tx_ready=1 drains 0..15 in order, and out_busy clears one cycle after the first pop.
- Assert rstn=0 mid-instruction-word (2 of 4 bytes received), then reload -> partial bytes discarded; first instr_we goes to address 0x0 with the full new word.

Source files
------------

// File: rtl/io_loader_router.sv
// Byte-stream front end: loads instruction and data images word by word after
// reset, then carries run-mode input words and output bytes through two FIFOs.
module io_loader_router #(
    parameter int          WORD_BYTES = 4,
    parameter logic [31:0] INSTR_BASE = 32'h0,
    parameter logic [31:0] DATA_BASE  = 32'h40000,
    parameter int unsigned ADDR_STEP  = WORD_BYTES,
    parameter int          IN_DEPTH   = 8,
    parameter int          OUT_DEPTH  = 16,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    instr_we,
    output logic [31:0]             instr_addr,
    output logic [8*WORD_BYTES-1:0] instr_wdata,
    output logic                    data_wvalid,
    input  logic                    data_wready,
    output logic [31:0]             data_addr,
    output logic [8*WORD_BYTES-1:0] data_wdata,
    output logic                    io_stall,
    output logic                    in_valid,
    output logic [8*WORD_BYTES-1:0] in_data,
    input  logic                    in_ready,
    input  logic                    out_valid,
    input  logic [7:0]              out_data,
    output logic                    out_busy,
    output logic                    err_overrun,
    output logic [2:0]              load_state
);
    localparam int W       = 8 * WORD_BYTES;
    localparam int BC_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int IN_AW   = $clog2(IN_DEPTH);
    localparam int OUT_AW  = $clog2(OUT_DEPTH);
    localparam logic [BC_W-1:0]   BC_ONE  = 1;
    localparam logic [BC_W-1:0]   BC_LAST = BC_W'(WORD_BYTES - 1);
    localparam logic [IN_AW:0]    IN_ONE  = 1;
    localparam logic [OUT_AW:0]   OUT_ONE = 1;
    localparam logic [31:0]       STEP    = 32'(ADDR_STEP);

    typedef enum logic [2:0] {
        S_ILEN  = 3'd0,
        S_INSTR = 3'd1,
        S_DLEN  = 3'd2,
        S_DATA  = 3'd3,
        S_DRAIN = 3'd4,
        S_RUN   = 3'd5
    } state_t;

    state_t            r_state, w_state_next;
    logic [BC_W-1:0]   r_byte_cnt;
    logic [W-1:0]      r_shift, w_shift_next;
    logic              r_word_done;
    logic [31:0]       w_word_lo;
    logic [31:0]       r_remaining;
    logic              r_instr_we, r_data_wvalid, r_io_stall, r_overrun;
    logic [31:0]       r_instr_addr, r_data_addr;
    logic [W-1:0]      r_instr_wdata, r_data_wdata;

    generate
        if (WORD_BYTES == 1) begin : g_shift_one
            assign w_shift_next = rx_data;
        end else if (BIG_ENDIAN) begin : g_shift_be
            assign w_shift_next = {r_shift[W-9:0], rx_data};
        end else begin : g_shift_le
            assign w_shift_next = {rx_data, r_shift[W-1:8]};
        end
    endgenerate

    // r_shift holds the finished word during the cycle r_word_done is high.
    assign w_word_lo = 32'(r_shift);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_byte_cnt  <= '0;
            r_shift     <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= rx_valid && (r_byte_cnt == BC_LAST);
            if (rx_valid) begin
                r_shift    <= w_shift_next;
                r_byte_cnt <= (r_byte_cnt == BC_LAST) ? '0 : r_byte_cnt + BC_ONE;
            end
        end
    end

    // ---------------- load / run sequencer ----------------
    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_ILEN;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_ILEN:  if (r_word_done) w_state_next = (w_word_lo == 32'd0) ? S_DLEN : S_INSTR;
            S_INSTR: if (r_word_done && r_remaining == 32'd1) w_state_next = S_DLEN;
            S_DLEN:  if (r_word_done) w_state_next = (w_word_lo == 32'd0) ? S_RUN : S_DATA;
            S_DATA:  if (r_word_done && r_remaining == 32'd1) w_state_next = S_DRAIN;
            S_DRAIN: if (!r_data_wvalid || data_wready) w_state_next = S_RUN;
            S_RUN:   w_state_next = S_RUN;
            default: w_state_next = S_ILEN;
        endcase
    end

    logic w_data_accept, w_data_load, w_data_drop;
    logic w_in_drop;
    assign w_data_accept = r_data_wvalid && data_wready;
    assign w_data_load   = (r_state == S_DATA) && r_word_done && (!r_data_wvalid || w_data_accept);
    assign w_data_drop   = (r_state == S_DATA) && r_word_done && r_data_wvalid && !w_data_accept;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_remaining   <= '0;
            r_instr_we    <= 1'b0;
            r_instr_addr  <= INSTR_BASE;
            r_instr_wdata <= '0;
            r_data_wvalid <= 1'b0;
            r_data_addr   <= DATA_BASE;
            r_data_wdata  <= '0;
            r_io_stall    <= 1'b1;
            r_overrun     <= 1'b0;
        end else begin
            if (r_word_done) begin
                if (r_state == S_ILEN || r_state == S_DLEN)
                    r_remaining <= w_word_lo;
                else if (r_state == S_INSTR || r_state == S_DATA)
                    r_remaining <= r_remaining - 32'd1;
            end
            r_instr_we <= (r_state == S_INSTR) && r_word_done;
            if ((r_state == S_INSTR) && r_word_done) r_instr_wdata <= r_shift;
            if (r_instr_we) r_instr_addr <= r_instr_addr + STEP;
            if (w_data_load) begin
                r_data_wvalid <= 1'b1;
                r_data_wdata  <= r_shift;
            end else if (w_data_accept) begin
                r_data_wvalid <= 1'b0;
            end
            if (w_data_accept) r_data_addr <= r_data_addr + STEP;
            r_io_stall <= (w_state_next != S_RUN);
            if (w_data_drop || w_in_drop) r_overrun <= 1'b1;
        end
    end

    // ---------------- input FIFO (words to core) ----------------
    logic [W-1:0]   r_in_mem [IN_DEPTH];
    logic [IN_AW:0] r_in_wr, r_in_rd;
    logic           w_in_empty, w_in_full, w_in_req, w_in_push, w_in_pop;

    assign w_in_empty = (r_in_wr == r_in_rd);
    assign w_in_full  = (r_in_wr[IN_AW] != r_in_rd[IN_AW]) &&
                        (r_in_wr[IN_AW-1:0] == r_in_rd[IN_AW-1:0]);
    // A word finishing while the last data write drains is already run-mode traffic.
    assign w_in_req   = r_word_done && (r_state == S_RUN || r_state == S_DRAIN);
    assign w_in_pop   = !w_in_empty && in_ready;
    assign w_in_push  = w_in_req && (!w_in_full || w_in_pop);
    assign w_in_drop  = w_in_req && w_in_full && !w_in_pop;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_in_wr <= '0;
            r_in_rd <= '0;
        end else begin
            if (w_in_push) r_in_wr <= r_in_wr + IN_ONE;
            if (w_in_pop)  r_in_rd <= r_in_rd + IN_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_push) r_in_mem[r_in_wr[IN_AW-1:0]] <= r_shift;
    end

    // ---------------- output FIFO (bytes to transmitter) ----------------
    logic [7:0]      r_out_mem [OUT_DEPTH];
    logic [OUT_AW:0] r_out_wr, r_out_rd;
    logic            w_out_empty, w_out_full, w_out_push, w_out_pop;

    assign w_out_empty = (r_out_wr == r_out_rd);
    assign w_out_full  = (r_out_wr[OUT_AW] != r_out_rd[OUT_AW]) &&
                         (r_out_wr[OUT_AW-1:0] == r_out_rd[OUT_AW-1:0]);
    assign w_out_push  = out_valid && !w_out_full;
    assign w_out_pop   = !w_out_empty && tx_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_out_wr <= '0;
            r_out_rd <= '0;
        end else begin
            if (w_out_push) r_out_wr <= r_out_wr + OUT_ONE;
            if (w_out_pop)  r_out_rd <= r_out_rd + OUT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_out_push) r_out_mem[r_out_wr[OUT_AW-1:0]] <= out_data;
    end

    assign instr_we    = r_instr_we;
    assign instr_addr  = r_instr_addr;
    assign instr_wdata = r_instr_wdata;
    assign data_wvalid = r_data_wvalid;
    assign data_addr   = r_data_addr;
    assign data_wdata  = r_data_wdata;
    assign io_stall    = r_io_stall;
    assign in_valid    = !w_in_empty;
    assign in_data     = r_in_mem[r_in_rd[IN_AW-1:0]];
    assign tx_valid    = !w_out_empty;
    assign tx_data     = r_out_mem[r_out_rd[OUT_AW-1:0]];
    assign out_busy    = w_out_full;
    assign err_overrun = r_overrun;
    assign load_state  = r_state;
endmodule

// File: tb/tb_io_loader_router.sv
// Directed bench for io_loader_router: image loading, data back-pressure,
// run-mode FIFOs and reset during a partial word.
module tb_io_loader_router;
    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        instr_we;
    logic [31:0] instr_addr;
    logic [31:0] instr_wdata;
    logic        data_wvalid;
    logic        data_wready;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        io_stall;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_busy;
    logic        err_overrun;
    logic [2:0]  load_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] iw_addr_q[$], iw_data_q[$], dw_addr_q[$], dw_data_q[$];
    bit seen_drain;
    logic [31:0] words [10];

    io_loader_router dut (
        .clk(clk), .rstn(rstn),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .instr_we(instr_we), .instr_addr(instr_addr), .instr_wdata(instr_wdata),
        .data_wvalid(data_wvalid), .data_wready(data_wready),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .io_stall(io_stall),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_busy(out_busy),
        .err_overrun(err_overrun), .load_state(load_state)
    );

    always #5 clk = ~clk;

    // Transaction monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (instr_we) begin
                iw_addr_q.push_back(instr_addr);
                iw_data_q.push_back(instr_wdata);
                $display("instr write addr=%h data=%h", instr_addr, instr_wdata);
            end
            if (data_wvalid && data_wready) begin
                dw_addr_q.push_back(data_addr);
                dw_data_q.push_back(data_wdata);
                $display("data write addr=%h data=%h", data_addr, data_wdata);
            end
            if (load_state == 3'd4) seen_drain = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00;
        tx_ready = 1'b0; data_wready = 1'b0;
        in_ready = 1'b0; out_valid = 1'b0; out_data = 8'h00;
        tick(3);
        iw_addr_q.delete(); iw_data_q.delete();
        dw_addr_q.delete(); dw_data_q.delete();
        seen_drain = 1'b0;
        rstn = 1'b1;
        tick(1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    // Finish a word with a core pop in exactly its word-done cycle.
    task automatic send_word_pop(input logic [31:0] w);
        for (int i = 0; i < 3; i++) send_byte(w[8*i +: 8]);
        rx_data = w[31:24]; rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0; in_ready = 1'b1;
        tick(1);
        in_ready = 1'b0;
    endtask

    initial begin
        // ---- reset values ----
        rstn = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0; data_wready = 1'b0;
        in_ready = 1'b0; out_valid = 1'b0; out_data = 8'h00;
        tick(3);
        chk("rst_state", 64'(load_state), 64'd0);
        chk("rst_stall", 64'(io_stall), 64'd1);
        chk("rst_instr_we", 64'(instr_we), 64'd0);
        chk("rst_data_wvalid", 64'(data_wvalid), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_in_valid", 64'(in_valid), 64'd0);
        chk("rst_out_busy", 64'(out_busy), 64'd0);
        chk("rst_overrun", 64'(err_overrun), 64'd0);
        chk("rst_instr_addr", 64'(instr_addr), 64'h0);
        chk("rst_data_addr", 64'(data_addr), 64'h40000);

        // ---- N=2 instruction image, M=0 ----
        do_reset();
        send_word(32'd2);
        send_word(32'h11223344);
        send_word(32'hAABBCCDD);
        chk("t1_stall_before_dlen", 64'(io_stall), 64'd1);
        send_word(32'd0);
        tick(3);
        chk("t1_instr_count", 64'(iw_addr_q.size()), 64'd2);
        chk("t1_iw0_addr", 64'(iw_addr_q[0]), 64'h0);
        chk("t1_iw0_data", 64'(iw_data_q[0]), 64'h11223344);
        chk("t1_iw1_addr", 64'(iw_addr_q[1]), 64'h4);
        chk("t1_iw1_data", 64'(iw_data_q[1]), 64'hAABBCCDD);
        chk("t1_instr_addr_next", 64'(instr_addr), 64'h8);
        chk("t1_stall", 64'(io_stall), 64'd0);
        chk("t1_state", 64'(load_state), 64'd5);
        chk("t1_no_data", 64'(dw_addr_q.size()), 64'd0);

        // ---- N=0, M=3, wready tied high ----
        do_reset();
        data_wready = 1'b1;
        send_word(32'd0);
        send_word(32'd3);
        send_word(32'hD0000001);
        send_word(32'hD0000002);
        send_word(32'hD0000003);
        tick(4);
        chk("t2_data_count", 64'(dw_addr_q.size()), 64'd3);
        chk("t2_dw0_addr", 64'(dw_addr_q[0]), 64'h40000);
        chk("t2_dw1_addr", 64'(dw_addr_q[1]), 64'h40004);
        chk("t2_dw2_addr", 64'(dw_addr_q[2]), 64'h40008);
        chk("t2_dw2_data", 64'(dw_data_q[2]), 64'hD0000003);
        chk("t2_seen_drain", 64'(seen_drain), 64'd1);
        chk("t2_state", 64'(load_state), 64'd5);
        chk("t2_stall", 64'(io_stall), 64'd0);
        chk("t2_overrun", 64'(err_overrun), 64'd0);
        chk("t2_no_instr", 64'(iw_addr_q.size()), 64'd0);

        // ---- M=2 with wready held low: second word dropped ----
        do_reset();
        send_word(32'd0);
        send_word(32'd2);
        send_word(32'hCAFE0001);
        send_word(32'hCAFE0002);
        tick(10);
        chk("t3_wvalid_held", 64'(data_wvalid), 64'd1);
        chk("t3_addr_held", 64'(data_addr), 64'h40000);
        chk("t3_wdata_held", 64'(data_wdata), 64'hCAFE0001);
        chk("t3_overrun", 64'(err_overrun), 64'd1);
        chk("t3_state_drain", 64'(load_state), 64'd4);
        chk("t3_stall_drain", 64'(io_stall), 64'd1);
        data_wready = 1'b1;
        tick(3);
        chk("t3_data_count", 64'(dw_addr_q.size()), 64'd1);
        chk("t3_dw0_addr", 64'(dw_addr_q[0]), 64'h40000);
        chk("t3_dw0_data", 64'(dw_data_q[0]), 64'hCAFE0001);
        chk("t3_wvalid_drop", 64'(data_wvalid), 64'd0);
        chk("t3_addr_next", 64'(data_addr), 64'h40004);
        chk("t3_state_run", 64'(load_state), 64'd5);

        // ---- run mode input FIFO ----
        do_reset();
        send_word(32'd0);
        send_word(32'd0);
        tick(2);
        chk("t4_state_run", 64'(load_state), 64'd5);
        chk("t4_in_empty", 64'(in_valid), 64'd0);
        for (int k = 0; k < 10; k++) words[k] = 32'h1000_0000 + 32'(k * 32'h0101);
        for (int k = 0; k < 8; k++) send_word(words[k]);
        tick(2);
        chk("t4_in_valid", 64'(in_valid), 64'd1);
        chk("t4_head_w0", 64'(in_data), 64'(words[0]));
        chk("t4_no_overrun_full", 64'(err_overrun), 64'd0);
        send_word_pop(words[8]);
        tick(2);
        chk("t4_pushpop_full_no_overrun", 64'(err_overrun), 64'd0);
        chk("t4_head_w1", 64'(in_data), 64'(words[1]));
        send_word(words[9]);
        tick(2);
        chk("t4_overrun_9th", 64'(err_overrun), 64'd1);
        for (int k = 1; k < 9; k++) begin
            chk($sformatf("t4_pop_valid_%0d", k), 64'(in_valid), 64'd1);
            chk($sformatf("t4_pop_data_%0d", k), 64'(in_data), 64'(words[k]));
            in_ready = 1'b1;
            tick(1);
            in_ready = 1'b0;
        end
        chk("t4_in_drained", 64'(in_valid), 64'd0);

        // ---- reset in the middle of the length word ----
        do_reset();
        send_byte(8'h55);
        send_byte(8'h66);
        do_reset();
        send_word(32'd1);
        send_word(32'hCAFEF00D);
        send_word(32'd0);
        tick(3);
        chk("t6_instr_count", 64'(iw_addr_q.size()), 64'd1);
        chk("t6_iw0_addr", 64'(iw_addr_q[0]), 64'h0);
        chk("t6_iw0_data", 64'(iw_data_q[0]), 64'hCAFEF00D);
        chk("t6_state", 64'(load_state), 64'd5);

        // ---- output FIFO: 20 pushes into 16 slots ----
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (i == 15) chk("t5_not_busy_15", 64'(out_busy), 64'd0);
            if (i == 16) chk("t5_busy_16", 64'(out_busy), 64'd1);
            out_data = 8'(i); out_valid = 1'b1;
            tick(1);
        end
        out_valid = 1'b0;
        chk("t5_busy_after", 64'(out_busy), 64'd1);
        tx_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("t5_tx_valid_%0d", k), 64'(tx_valid), 64'd1);
            chk($sformatf("t5_tx_data_%0d", k), 64'(tx_data), 64'(k));
            tick(1);
            if (k == 0) chk("t5_busy_clear", 64'(out_busy), 64'd0);
        end
        chk("t5_tx_empty", 64'(tx_valid), 64'd0);
        tx_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
